// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - request, data-memory and writeback signal bundle for the lsu
//
// Purpose: groups every non-clock/reset port of the lsu.
// Ports (slave = lsu view):
//   request  : req_valid, req_ready, is_store, funct3, addr, store_data, rd_addr
//   memory   : mem_req, mem_we, mem_addr, mem_wdata, mem_be, mem_ack, mem_rdata
//   writeback: wb_we, wb_a3, wb_wd
//   status   : done, err, err_code
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [4:0]  rd_addr;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        wb_we;
  logic [4:0]  wb_a3;
  logic [31:0] wb_wd;

  logic        done;
  logic        err;
  logic [1:0]  err_code;

  modport slave (
    input  req_valid, is_store, funct3, addr, store_data, rd_addr, mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           wb_we, wb_a3, wb_wd, done, err, err_code
  );

  modport master (
    output req_valid, is_store, funct3, addr, store_data, rd_addr, mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           wb_we, wb_a3, wb_wd, done, err, err_code
  );
endinterface

// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I load/store unit with single-request capture and access timeout
//
// Purpose: accepts one load/store at a time, checks width code and alignment,
// drives a word-addressed data-memory access with byte enables, extracts and
// extends load data into the register-file write port, and reports completion
// (done) and errors (err/err_code) as one-cycle pulses.
// Ports:
//   clk   : clock, all state updates on posedge
//   reset : asynchronous active-high reset
//   bus   : lsu_if.slave (request, memory, writeback and status signals)
module lsu #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic  clk,
  input  logic  reset,
  lsu_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, WB, ERR} state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  state_t        state, state_nxt;
  logic [CW-1:0] tcnt;
  logic          r_store;
  logic [2:0]    r_funct3;
  logic [31:0]   r_addr;
  logic [31:0]   r_data;
  logic [4:0]    r_rd;
  logic [31:0]   wb_wd_q;
  logic [4:0]    wb_a3_q;
  logic [1:0]    err_code_q, err_code_nxt;

  logic          accept;
  logic          illegal;
  logic          misaligned;
  logic          timeout_hit;
  logic [31:0]   lane;
  logic [31:0]   load_val;
  logic [3:0]    store_be;

  assign accept      = bus.req_valid && (state == IDLE);
  // Last permitted ACCESS cycle: counter holds the number of ack-less cycles so far.
  assign timeout_hit = (tcnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    illegal = 1'b1;
    case (bus.funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = bus.is_store;
      default:                illegal = 1'b1;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    case (bus.funct3)
      3'b001, 3'b101: misaligned = bus.addr[0];
      3'b010:         misaligned = (bus.addr[1:0] != 2'b00);
      default:        misaligned = 1'b0;
    endcase
  end

  always_comb begin
    store_be = 4'b1111;
    case (r_funct3[1:0])
      2'b00:   store_be = 4'b0001 << r_addr[1:0];
      2'b01:   store_be = 4'b0011 << {r_addr[1], 1'b0};
      default: store_be = 4'b1111;
    endcase
  end

  always_comb begin
    bus.mem_wdata = r_data;
    case (r_funct3[1:0])
      2'b00:   bus.mem_wdata = {4{r_data[7:0]}};
      2'b01:   bus.mem_wdata = {2{r_data[15:0]}};
      default: bus.mem_wdata = r_data;
    endcase
  end

  assign lane = bus.mem_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    load_val = lane;
    case (r_funct3)
      3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_val = {24'h0, lane[7:0]};
      3'b101:  load_val = {16'h0, lane[15:0]};
      default: load_val = lane;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    err_code_nxt = err_code_q;
    case (state)
      IDLE: begin
        if (accept) begin
          // Width-code check outranks alignment.
          if (illegal) begin
            state_nxt    = ERR;
            err_code_nxt = 2'b10;
          end else if (misaligned) begin
            state_nxt    = ERR;
            err_code_nxt = 2'b01;
          end else begin
            state_nxt = ACCESS;
          end
        end
      end
      ACCESS: begin
        // An ack on the final permitted cycle still completes normally.
        if (bus.mem_ack) begin
          state_nxt = WB;
        end else if (timeout_hit) begin
          state_nxt    = ERR;
          err_code_nxt = 2'b11;
        end
      end
      WB:      state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.mem_req   = (state == ACCESS);
  assign bus.mem_we    = (state == ACCESS) && r_store;
  assign bus.mem_be    = ((state == ACCESS) && r_store) ? store_be : 4'b0000;
  assign bus.mem_addr  = {r_addr[31:2], 2'b00};
  assign bus.done      = (state == WB) || (state == ERR);
  assign bus.err       = (state == ERR);
  assign bus.err_code  = err_code_q;
  assign bus.wb_we     = (state == WB) && !r_store && (r_rd != 5'd0);
  assign bus.wb_a3     = wb_a3_q;
  assign bus.wb_wd     = wb_wd_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt       <= '0;
      r_store    <= 1'b0;
      r_funct3   <= 3'b000;
      r_addr     <= 32'h0;
      r_data     <= 32'h0;
      r_rd       <= 5'd0;
      wb_wd_q    <= 32'h0;
      wb_a3_q    <= 5'd0;
      err_code_q <= 2'b00;
    end else begin
      err_code_q <= err_code_nxt;
      if (accept) begin
        r_store  <= bus.is_store;
        r_funct3 <= bus.funct3;
        r_addr   <= bus.addr;
        r_data   <= bus.store_data;
        r_rd     <= bus.rd_addr;
        tcnt     <= '0;
      end
      if (state == ACCESS) begin
        if (bus.mem_ack) begin
          wb_a3_q <= r_rd;
          if (!r_store) wb_wd_q <= load_val;
        end else begin
          tcnt <= tcnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed scoreboard testbench for lsu
module tb_lsu;
  localparam int TO = 64;

  typedef struct {
    logic        err;
    logic [1:0]  code;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  lsu_if bus();

  lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rd,
                       input bit push, input exp_t e);
    @(negedge clk);
    chk("req_ready_idle", {31'h0, bus.req_ready}, 32'd1);
    bus.req_valid  = 1'b1;
    bus.is_store   = st;
    bus.funct3     = f3;
    bus.addr       = a;
    bus.store_data = d;
    bus.rd_addr    = rd;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.is_store   = 1'($urandom);
    bus.funct3     = 3'($urandom);
    bus.addr       = $urandom;
    bus.store_data = $urandom;
    bus.rd_addr    = 5'($urandom);
  endtask

  // Serves the memory side; acks after wait_cycles extra cycles of mem_req.
  task automatic access(input string tag, input int wait_cycles, input logic [31:0] rdata,
                        input logic [3:0] be, input logic [31:0] wd, input bit cw,
                        input logic we, input logic [31:0] ma, input int exp_n);
    int n;
    bit held;
    n    = 0;
    held = 1'b1;
    @(negedge clk);
    while (bus.mem_req && n < 200) begin
      if (bus.mem_be !== be || bus.mem_we !== we || bus.mem_addr !== ma ||
          (cw && bus.mem_wdata !== wd)) held = 1'b0;
      n++;
      if (n == wait_cycles + 1) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
      end
      @(posedge clk);
      #1;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = $urandom;
      @(negedge clk);
    end
    chk({tag, "_mem_req_cycles"}, 32'(n), 32'(exp_n));
    chk({tag, "_mem_fields_held"}, {31'h0, held}, 32'd1);
  endtask

  task automatic expect_done(input string tag);
    exp_t e;
    chk({tag, "_done"}, {31'h0, bus.done}, 32'd1);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_err"}, {31'h0, bus.err}, {31'h0, e.err});
      if (e.err) chk({tag, "_err_code"}, {30'h0, bus.err_code}, {30'h0, e.code});
      chk({tag, "_wb_we"}, {31'h0, bus.wb_we}, {31'h0, e.we});
      if (e.we) begin
        chk({tag, "_wb_a3"}, {27'h0, bus.wb_a3}, {27'h0, e.a3});
        chk({tag, "_wb_wd"}, bus.wb_wd, e.wd);
      end
    end
  endtask

  task automatic err_case(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [1:0] code);
    issue(st, f3, a, 32'h0, 5'd1, 1'b1, '{1'b1, code, 1'b0, 5'd0, 32'h0});
    @(negedge clk);
    chk({tag, "_no_mem_req"}, {31'h0, bus.mem_req}, 32'd0);
    expect_done(tag);
  endtask

  initial begin
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.is_store   = 1'b0;
    bus.funct3     = 3'b000;
    bus.addr       = 32'h0;
    bus.store_data = 32'h0;
    bus.rd_addr    = 5'd0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = 32'h0;
    #2;
    chk("rst_req_ready", {31'h0, bus.req_ready}, 32'd1);
    chk("rst_mem_req",   {31'h0, bus.mem_req}, 32'd0);
    chk("rst_mem_be",    {28'h0, bus.mem_be}, 32'd0);
    chk("rst_mem_addr",  bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_done",      {31'h0, bus.done}, 32'd0);
    chk("rst_err",       {31'h0, bus.err}, 32'd0);
    chk("rst_wb_we",     {31'h0, bus.wb_we}, 32'd0);
    chk("rst_wb_wd",     bus.wb_wd, 32'h0);
    chk("rst_err_code",  {30'h0, bus.err_code}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // LB sign-extended from top byte lane
    issue(1'b0, 3'b000, 32'h0000_1003, 32'h0, 5'd5, 1'b1, '{1'b0, 2'd0, 1'b1, 5'd5, 32'hFFFF_FF80});
    access("lb", 1, 32'h80FF_EE11, 4'b0000, 32'h0, 1'b0, 1'b0, 32'h0000_1000, 2);
    expect_done("lb");

    // SH upper half, three wait cycles
    issue(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 5'd3, 1'b1, '{1'b0, 2'd0, 1'b0, 5'd0, 32'h0});
    access("sh", 3, 32'h0, 4'b1100, 32'hABCD_ABCD, 1'b1, 1'b1, 32'h0000_2000, 4);
    expect_done("sh");

    issue(1'b1, 3'b000, 32'h0000_3001, 32'h1111_115A, 5'd0, 1'b1, '{1'b0, 2'd0, 1'b0, 5'd0, 32'h0});
    access("sb", 0, 32'h0, 4'b0010, 32'h5A5A_5A5A, 1'b1, 1'b1, 32'h0000_3000, 1);
    expect_done("sb");

    issue(1'b1, 3'b010, 32'h0000_4000, 32'hDEAD_BEEF, 5'd2, 1'b1, '{1'b0, 2'd0, 1'b0, 5'd0, 32'h0});
    access("sw", 2, 32'h0, 4'b1111, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0000_4000, 3);
    expect_done("sw");

    issue(1'b0, 3'b001, 32'h0000_0002, 32'h0, 5'd10, 1'b1, '{1'b0, 2'd0, 1'b1, 5'd10, 32'hFFFF_8001});
    access("lh", 0, 32'h8001_1234, 4'b0000, 32'h0, 1'b0, 1'b0, 32'h0000_0000, 1);
    expect_done("lh");

    issue(1'b0, 3'b100, 32'h0000_0001, 32'h0, 5'd11, 1'b1, '{1'b0, 2'd0, 1'b1, 5'd11, 32'h0000_00F5});
    access("lbu", 0, 32'h0000_F500, 4'b0000, 32'h0, 1'b0, 1'b0, 32'h0000_0000, 1);
    expect_done("lbu");

    err_case("lw_misal",   1'b0, 3'b010, 32'h0000_0006, 2'b01);
    err_case("f3_011",     1'b0, 3'b011, 32'h0000_0000, 2'b10);
    err_case("sbu_store",  1'b1, 3'b100, 32'h0000_0000, 2'b10);
    err_case("f3_111_pri", 1'b0, 3'b111, 32'h0000_0003, 2'b10);
    err_case("lh_misal",   1'b0, 3'b001, 32'h0000_0001, 2'b01);

    // Timeout, then ack on the final permitted cycle
    issue(1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd6, 1'b1, '{1'b1, 2'b11, 1'b0, 5'd0, 32'h0});
    access("lw_to", 1000, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b0, 32'h0000_0100, TO);
    expect_done("lw_to");

    issue(1'b0, 3'b010, 32'h0000_0104, 32'h0, 5'd7, 1'b1, '{1'b0, 2'd0, 1'b1, 5'd7, 32'hCAFE_F00D});
    access("lw_last", TO - 1, 32'hCAFE_F00D, 4'b0000, 32'h0, 1'b0, 1'b0, 32'h0000_0104, TO);
    expect_done("lw_last");

    // LHU to x0: completes without writeback
    issue(1'b0, 3'b101, 32'h0000_6002, 32'h0, 5'd0, 1'b1, '{1'b0, 2'd0, 1'b0, 5'd0, 32'h0});
    access("lhu_x0", 0, 32'hBEEF_0000, 4'b0000, 32'h0, 1'b0, 1'b0, 32'h0000_6000, 1);
    expect_done("lhu_x0");

    // Reset in the middle of an access
    issue(1'b0, 3'b010, 32'h0000_0500, 32'h0, 5'd9, 1'b0, '{1'b0, 2'd0, 1'b0, 5'd0, 32'h0});
    @(negedge clk);
    chk("abort_mem_req_before", {31'h0, bus.mem_req}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_mem_req",   {31'h0, bus.mem_req}, 32'd0);
    chk("abort_req_ready", {31'h0, bus.req_ready}, 32'd1);
    chk("abort_done",      {31'h0, bus.done}, 32'd0);
    chk("abort_mem_be",    {28'h0, bus.mem_be}, 32'd0);
    @(negedge clk);
    reset         = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("late_ack_done",  {31'h0, bus.done}, 32'd0);
      chk("late_ack_wb_we", {31'h0, bus.wb_we}, 32'd0);
      chk("late_ack_req",   {31'h0, bus.mem_req}, 32'd0);
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
